jacobi_result_sender: RTL

JACOBI_RESULT_SENDER -- requirements
Module: jacobi_result_sender

---
 rtl/jacobi_result_sender.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jacobi_result_sender.sv
// jacobi_result_sender
//
// Streams the results of a Jacobi eigen-decomposition out of the result RAM
// to the microcontroller. The N diagonal entries of A are sent first, read at
// address N*i+i. They are followed by the N*N entries of V, read at
// V_OFFSET+N*r+c in row-major order. Reads go into a 2-entry FIFO. The FIFO
// head is presented on a valid/ready output port.
//
// Handshake: out_vld_o is high whenever the FIFO holds a word. It never
// depends on out_rdy_i. A word transfers on a rising edge where
// out_vld_o && out_rdy_i. out_dat_o holds steady while out_vld_o is high and
// the word has not yet transferred.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start_i       one-cycle request to send a result stream (IDLE only)
//   busy_o        high while a stream is in progress
//   done_o        one-cycle pulse after the last word transfers
//   ram_en_o      RAM read enable; data returns on ram_dout_i one cycle later
//   ram_addr_o    RAM read address (0 when no read is issued)
//   ram_dout_i    RAM read data
//   out_dat_o     FIFO head (0 when empty)
//   out_vld_o     FIFO not empty
//   out_rdy_i     consumer accepts the head word
//   dbg_state_o   current FSM state, for debug and checkers
module jacobi_result_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int N          = 8,
    parameter int V_OFFSET   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i,
    output logic [DATA_WIDTH-1:0] out_dat_o,
    output logic                  out_vld_o,
    input  logic                  out_rdy_i,
    output logic [2:0]            dbg_state_o
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_DIAG = 3'd1,
        SEND_V    = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  push, pop, sending, issue;
    logic [1:0]            room_used;
    logic [ADDR_WIDTH-1:0] addr_c;

    // FIFO datapath
    always_comb begin
        push     = inflight_q;                   // read issued last cycle returns now
        pop      = (occ_q != 2'd0) && out_rdy_i;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ram_dout_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Occupancy counts the word leaving this cycle as already gone. Without
    // that, a full-rate stream (one word held, one read in flight) would stall
    // every other cycle. The sum after an issue is still at most 2, so the
    // FIFO cannot overflow.
    always_comb begin
        room_used  = occ_q - {1'b0, pop} + {1'b0, inflight_q};
        sending    = (state_q == SEND_DIAG) || (state_q == SEND_V);
        issue      = sending && (room_used < 2'd2);
        inflight_d = issue;
    end

    // FSM, address generation and counters
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_c  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SEND_DIAG;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            SEND_DIAG: begin
                // The column counter is the diagonal index here.
                if (issue) begin
                    addr_c = ADDR_WIDTH'(col_q) * ADDR_WIDTH'(N + 1);
                    col_d  = (col_q == LAST) ? '0 : col_q + CNT_W'(1);
                    if (col_q == LAST) begin
                        state_d = SEND_V;
                    end
                end
            end
            SEND_V: begin
                if (issue) begin
                    addr_c = ADDR_WIDTH'(V_OFFSET) + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(N)
                           + ADDR_WIDTH'(col_q);
                    col_d  = (col_q == LAST) ? '0 : col_q + CNT_W'(1);
                    if (col_q == LAST) begin
                        row_d = (row_q == LAST) ? '0 : row_q + CNT_W'(1);
                        if (row_q == LAST) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    assign ram_en_o    = issue;
    assign ram_addr_o  = addr_c;
    assign out_vld_o   = (occ_q != 2'd0);
    assign out_dat_o   = out_vld_o ? fifo_q[rd_ptr_q] : '0;
    assign busy_o      = sending || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule
